// File: rtl/bg_cal_pkg.sv
// Shared types and helpers for the bandgap trim calibration scheduler.
// Codes are 12 bits; differences are carried in 13 bits so they never wrap.
package bg_cal_pkg;

  localparam int CODE_W = 12;
  localparam int DIFF_W = CODE_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RST_BG,
    SETTLE,
    CONFIRM,
    PUBLISH,
    DONE,
    ERROR
  } state_e;

  function automatic logic [DIFF_W-1:0] absdiff(input logic [CODE_W-1:0] a,
                                                input logic [CODE_W-1:0] b);
    logic [DIFF_W-1:0] ea;
    logic [DIFF_W-1:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

endpackage

// File: rtl/bg_cal_cmp.sv
// Combinational |a-b| <= LIMIT test on two trim codes.
module bg_cal_cmp
  import bg_cal_pkg::*;
#(
  parameter int LIMIT = 1
) (
  input  logic [CODE_W-1:0] a_i,
  input  logic [CODE_W-1:0] b_i,
  output logic              within_o
);

  logic [DIFF_W-1:0] diff;

  assign diff     = absdiff(a_i, b_i);
  assign within_o = (diff <= DIFF_W'(LIMIT));

endmodule

// File: rtl/bg_cal_sched.sv
// Supervisory scheduler around the bandgap trim SAR: power-up/reset sequencing,
// result confirmation, trim publication, periodic recal, timeout and drift flags.
module bg_cal_sched
  import bg_cal_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 4096,
  parameter int NUM_MATCH  = 3,
  parameter int TOL        = 1,
  parameter int DRIFT_MAX  = 16,
  parameter int INTERVAL   = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cal_req,
  input  logic              err_clr,
  input  logic              bg_valid,
  input  logic [7:0]        bg_idac_coarse,
  input  logic [7:0]        bg_idac_fine,
  output logic              bg_pwrup,
  output logic              bg_reset,
  output logic [CODE_W-1:0] trim_code,
  output logic              trim_valid,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_drift,
  output logic [7:0]        cal_count
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  state_e            state_q, state_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [IW-1:0]     int_q, int_d;
  logic [3:0]        match_q, match_d;
  logic [CODE_W-1:0] prev_q, prev_d;
  logic              pending_q, pending_d;
  logic [CODE_W-1:0] trim_code_q, trim_code_d;
  logic              trim_valid_q, trim_valid_d;
  logic [7:0]        cal_count_q, cal_count_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_drift_q, err_drift_d;
  logic              pwrup_q, pwrup_d;
  logic              bgrst_q, bgrst_d;
  logic              busy_q, busy_d;
  logic              valid_q;

  logic [CODE_W-1:0] code12;
  logic              valid_edge;
  logic              tol_ok;
  logic              drift_ok;
  logic              unused_fine;

  assign code12      = {bg_idac_coarse, bg_idac_fine[7:4]};
  assign valid_edge  = bg_valid & ~valid_q;
  assign unused_fine = ^bg_idac_fine[3:0];

  bg_cal_cmp #(.LIMIT(TOL)) u_tol_cmp (
    .a_i      (code12),
    .b_i      (prev_q),
    .within_o (tol_ok)
  );

  bg_cal_cmp #(.LIMIT(DRIFT_MAX)) u_drift_cmp (
    .a_i      (prev_q),
    .b_i      (trim_code_q),
    .within_o (drift_ok)
  );

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    wait_d        = wait_q;
    int_d         = int_q;
    match_d       = match_q;
    prev_d        = prev_q;
    pending_d     = pending_q;
    trim_code_d   = trim_code_q;
    trim_valid_d  = trim_valid_q;
    cal_count_d   = cal_count_q;
    err_timeout_d = err_timeout_q & ~err_clr;
    err_drift_d   = err_drift_q & ~err_clr;

    if (!enable) begin
      // Abort wins over any request in the same cycle; in-flight result is dropped.
      state_d   = IDLE;
      pending_d = 1'b0;
    end else begin
      if (busy_q && cal_req) pending_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (cal_req || pending_q) state_d = RST_BG;
        end
        RST_BG: begin
          if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = SETTLE;
          else                                  rst_cnt_d = rst_cnt_q + 1'b1;
        end
        SETTLE, CONFIRM: begin
          if (valid_edge) begin
            prev_d = code12;
            wait_d = '0;
            if (state_q == SETTLE || !tol_ok) match_d = 4'd1;
            else                              match_d = match_q + 1'b1;
            if (match_d == 4'(NUM_MATCH)) state_d = PUBLISH;
            else                          state_d = CONFIRM;
          end else if (wait_q == WW'(TIMEOUT - 1)) begin
            err_timeout_d = 1'b1;
            state_d       = ERROR;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        PUBLISH: begin
          if (trim_valid_q && !drift_ok) err_drift_d = 1'b1;
          trim_code_d  = prev_q;
          trim_valid_d = 1'b1;
          if (cal_count_q != 8'hFF) cal_count_d = cal_count_q + 1'b1;
          int_d   = '0;
          state_d = DONE;
        end
        DONE: begin
          if (cal_req || pending_q) begin
            state_d = RST_BG;
          end else if (INTERVAL > 0) begin
            if (int_q == IW'(INTERVAL - 1)) state_d = RST_BG;
            else                            int_d = int_q + 1'b1;
          end
        end
        ERROR: begin
          if (cal_req) state_d = RST_BG;
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d == RST_BG && state_q != RST_BG) begin
      rst_cnt_d = '0;
      wait_d    = '0;
      match_d   = '0;
      pending_d = 1'b0;
    end

    pwrup_d = (state_d == SETTLE) || (state_d == CONFIRM) ||
              (state_d == PUBLISH) || (state_d == DONE);
    bgrst_d = (state_d == RST_BG);
    busy_d  = (state_d == RST_BG) || (state_d == SETTLE) ||
              (state_d == CONFIRM) || (state_d == PUBLISH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rst_cnt_q     <= '0;
      wait_q        <= '0;
      int_q         <= '0;
      match_q       <= '0;
      prev_q        <= '0;
      pending_q     <= 1'b0;
      trim_code_q   <= '0;
      trim_valid_q  <= 1'b0;
      cal_count_q   <= '0;
      err_timeout_q <= 1'b0;
      err_drift_q   <= 1'b0;
      pwrup_q       <= 1'b0;
      bgrst_q       <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      wait_q        <= wait_d;
      int_q         <= int_d;
      match_q       <= match_d;
      prev_q        <= prev_d;
      pending_q     <= pending_d;
      trim_code_q   <= trim_code_d;
      trim_valid_q  <= trim_valid_d;
      cal_count_q   <= cal_count_d;
      err_timeout_q <= err_timeout_d;
      err_drift_q   <= err_drift_d;
      pwrup_q       <= pwrup_d;
      bgrst_q       <= bgrst_d;
      busy_q        <= busy_d;
      valid_q       <= bg_valid;
    end
  end

  assign bg_pwrup    = pwrup_q;
  assign bg_reset    = bgrst_q;
  assign trim_code   = trim_code_q;
  assign trim_valid  = trim_valid_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_drift   = err_drift_q;
  assign cal_count   = cal_count_q;

endmodule

// File: tb/tb_bg_cal_sched.sv
// Directed bench for bg_cal_sched: nominal, mismatch, timeout, drift, pending,
// periodic recal, abort and async reset scenarios with hand-computed expectations.
module tb_bg_cal_sched;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cal_req;
  logic        err_clr;
  logic        bg_valid;
  logic [7:0]  bg_idac_coarse;
  logic [7:0]  bg_idac_fine;
  logic        bg_pwrup;
  logic        bg_reset;
  logic [11:0] trim_code;
  logic        trim_valid;
  logic        busy;
  logic        err_timeout;
  logic        err_drift;
  logic [7:0]  cal_count;

  int checks   = 0;
  int failures = 0;

  bg_cal_sched #(.INTERVAL(100)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .cal_req        (cal_req),
    .err_clr        (err_clr),
    .bg_valid       (bg_valid),
    .bg_idac_coarse (bg_idac_coarse),
    .bg_idac_fine   (bg_idac_fine),
    .bg_pwrup       (bg_pwrup),
    .bg_reset       (bg_reset),
    .trim_code      (trim_code),
    .trim_valid     (trim_valid),
    .busy           (busy),
    .err_timeout    (err_timeout),
    .err_drift      (err_drift),
    .cal_count      (cal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle valid pulse; the low fine nibble carries junk the DUT must ignore.
  task automatic pulse(input logic [11:0] c, input logic [3:0] junk);
    bg_idac_coarse = c[11:4];
    bg_idac_fine   = {c[3:0], junk};
    bg_valid       = 1'b1;
    step();
    bg_valid       = 1'b0;
  endtask

  task automatic start_cal();
    cal_req = 1'b1;
    step();
    cal_req = 1'b0;
    repeat (4) step();
  endtask

  task automatic run_cal(input logic [11:0] c);
    pulse(c, 4'hF);
    repeat (4) step();
    pulse(c, 4'h3);
    repeat (4) step();
    pulse(c, 4'hA);
    step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if ({bg_pwrup, bg_reset, trim_code, trim_valid, busy, err_timeout, err_drift, cal_count} !== 25'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {bg_pwrup, bg_reset, trim_code, trim_valid, busy, err_timeout, err_drift, cal_count}); end
    reset  = 1'b0;
    enable = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    int n;
    cal_req = 1'b1;
    step();
    cal_req = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL nom_busy_rise got=%b exp=1", busy); end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bg_reset !== 1'b1) break;
      n++;
      step();
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL nom_reset_len got=%0d exp=4", n); end
    checks++; if (bg_pwrup !== 1'b1) begin failures++; $display("FAIL nom_pwrup got=%b exp=1", bg_pwrup); end
    repeat (35) step();
    pulse(12'h9A5, 4'h0);
    repeat (29) step();
    pulse(12'h9A5, 4'h0);
    repeat (29) step();
    pulse(12'h9A5, 4'h0);
    checks++; if (trim_valid !== 1'b0) begin failures++; $display("FAIL nom_early_valid got=%b exp=0", trim_valid); end
    step();
    checks++; if (trim_code !== 12'h9A5) begin failures++; $display("FAIL nom_code got=%h exp=9a5", trim_code); end
    checks++; if (trim_valid !== 1'b1) begin failures++; $display("FAIL nom_valid got=%b exp=1", trim_valid); end
    checks++; if (cal_count !== 8'd1) begin failures++; $display("FAIL nom_count got=%0d exp=1", cal_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nom_busy_fall got=%b exp=0", busy); end
  endtask

  task automatic test_mismatch();
    start_cal();
    pulse(12'h400, 4'h1);
    repeat (4) step();
    pulse(12'h402, 4'h2);
    repeat (4) step();
    pulse(12'h403, 4'h3);
    step();
    checks++; if (trim_code !== 12'h9A5) begin failures++; $display("FAIL mm_no_early_publish got=%h exp=9a5", trim_code); end
    repeat (3) step();
    pulse(12'h403, 4'h4);
    step();
    checks++; if (trim_code !== 12'h403) begin failures++; $display("FAIL mm_code got=%h exp=403", trim_code); end
    checks++; if (cal_count !== 8'd2) begin failures++; $display("FAIL mm_count got=%0d exp=2", cal_count); end
  endtask

  task automatic test_timeout();
    start_cal();
    repeat (4095) step();
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", err_timeout); end
    step();
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", err_timeout); end
    checks++; if ({bg_pwrup, busy} !== 2'b00) begin failures++; $display("FAIL to_pwrdn got=%b exp=00", {bg_pwrup, busy}); end
    checks++; if ({trim_valid, trim_code} !== 13'h1403) begin failures++; $display("FAIL to_trim_kept got=%h exp=1403", {trim_valid, trim_code}); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", err_timeout); end
    cal_req = 1'b1;
    step();
    cal_req = 1'b0;
    checks++; if (bg_reset !== 1'b1) begin failures++; $display("FAIL to_restart got=%b exp=1", bg_reset); end
    repeat (4) step();
  endtask

  task automatic test_drift();
    run_cal(12'h100);
    checks++; if ({err_drift, trim_code} !== 13'h1100) begin failures++; $display("FAIL dr_down got=%h exp=1100", {err_drift, trim_code}); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    start_cal();
    run_cal(12'h120);
    checks++; if (err_drift !== 1'b1) begin failures++; $display("FAIL dr_flag got=%b exp=1", err_drift); end
    checks++; if (trim_code !== 12'h120) begin failures++; $display("FAIL dr_code got=%h exp=120", trim_code); end
    checks++; if (cal_count !== 8'd4) begin failures++; $display("FAIL dr_count got=%0d exp=4", cal_count); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    start_cal();
    run_cal(12'h130);
    checks++; if ({err_drift, trim_code} !== 13'h0130) begin failures++; $display("FAIL dr_edge16 got=%h exp=0130", {err_drift, trim_code}); end
  endtask

  task automatic test_back_to_back();
    start_cal();
    pulse(12'h130, 4'h0);
    repeat (3) step();
    cal_req = 1'b1;
    step();
    cal_req = 1'b0;
    pulse(12'h130, 4'h0);
    repeat (4) step();
    pulse(12'h130, 4'h0);
    step();
    checks++; if ({busy, bg_reset, cal_count} !== 10'h006) begin failures++; $display("FAIL b2b_done got=%h exp=006", {busy, bg_reset, cal_count}); end
    step();
    checks++; if ({busy, bg_reset} !== 2'b11) begin failures++; $display("FAIL b2b_pending got=%b exp=11", {busy, bg_reset}); end
    repeat (4) step();
    run_cal(12'h130);
  endtask

  task automatic test_periodic_abort();
    repeat (99) step();
    checks++; if (bg_reset !== 1'b0) begin failures++; $display("FAIL per_early got=%b exp=0", bg_reset); end
    step();
    checks++; if (bg_reset !== 1'b1) begin failures++; $display("FAIL per_recal got=%b exp=1", bg_reset); end
    repeat (4) step();
    pulse(12'h200, 4'h0);
    repeat (2) step();
    enable  = 1'b0;
    cal_req = 1'b1;
    step();
    cal_req = 1'b0;
    checks++; if ({bg_pwrup, bg_reset, busy} !== 3'b000) begin failures++; $display("FAIL ab_idle got=%b exp=000", {bg_pwrup, bg_reset, busy}); end
    checks++; if ({trim_valid, trim_code, cal_count} !== 21'h113007) begin failures++; $display("FAIL ab_trim_kept got=%h exp=113007", {trim_valid, trim_code, cal_count}); end
    enable = 1'b1;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ab_no_pending got=%b exp=0", busy); end
  endtask

  task automatic test_async_reset();
    start_cal();
    pulse(12'h300, 4'h0);
    repeat (4) step();
    pulse(12'h300, 4'h0);
    #3;
    reset = 1'b1;
    #1;
    checks++; if ({bg_pwrup, bg_reset, trim_code, trim_valid, busy, err_timeout, err_drift, cal_count} !== 25'd0) begin failures++; $display("FAIL ar_outputs got=%h exp=0", {bg_pwrup, bg_reset, trim_code, trim_valid, busy, err_timeout, err_drift, cal_count}); end
    step();
    reset          = 1'b0;
    bg_idac_coarse = 8'h30;
    bg_idac_fine   = 8'h00;
    bg_valid       = 1'b1;
    cal_req        = 1'b1;
    step();
    bg_valid = 1'b0;
    cal_req  = 1'b0;
    checks++; if ({bg_reset, bg_pwrup} !== 2'b10) begin failures++; $display("FAIL ar_req_edge got=%b exp=10", {bg_reset, bg_pwrup}); end
    repeat (4) step();
    run_cal(12'h555);
    checks++; if ({trim_valid, trim_code, cal_count} !== 21'h155501) begin failures++; $display("FAIL ar_nominal got=%h exp=155501", {trim_valid, trim_code, cal_count}); end
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    cal_req        = 1'b0;
    err_clr        = 1'b0;
    bg_valid       = 1'b0;
    bg_idac_coarse = 8'h00;
    bg_idac_fine   = 8'h00;
    test_reset();
    test_nominal();
    test_mismatch();
    test_timeout();
    test_drift();
    test_back_to_back();
    test_periodic_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
